// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-counter chain: direction enum,
// per-channel modulus extraction and load-value clamping.
package counter_pkg;

    localparam int DW_DEF = 8;
    localparam int MODS_MAXW = 256;

    typedef enum logic {
        DN = 1'b0,
        UP = 1'b1
    } dir_e;

    // Modulus of channel i from a packed MODS vector (zero-extended to MODS_MAXW).
    function automatic int mod_at(input logic [MODS_MAXW-1:0] mods, input int i, input int dw);
        logic [MODS_MAXW-1:0] mask;
        mask = (MODS_MAXW'(1) << dw) - MODS_MAXW'(1);
        return int'((mods >> (i * dw)) & mask);
    endfunction

    function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] hi);
        return (v > hi) ? hi : v;
    endfunction

endpackage

// File: rtl/counter_mod_chain_if.sv
// Control/status bundle of the counter chain: stepping controls, per-channel
// load request, and the registered counts with their terminal-count flags.
interface counter_mod_chain_if
    import counter_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int NCH = 3,
    parameter int LCW = (NCH > 1) ? $clog2(NCH) : 1
);
    logic              ena;
    logic              up;
    logic              sat;
    logic              load;
    logic [LCW-1:0]    load_ch;
    logic [DW-1:0]     load_val;
    logic [NCH*DW-1:0] count;
    logic [NCH-1:0]    tc;
    logic              tc_all;

    modport master (
        output ena, up, sat, load, load_ch, load_val,
        input  count, tc, tc_all
    );

    modport slave (
        input  ena, up, sat, load, load_ch, load_val,
        output count, tc, tc_all
    );
endinterface

// File: rtl/counter_mod_cell.sv
// One modulo-MOD channel: up/down step with optional wrap suppression,
// clamped parallel load, and a combinational "at terminal" flag.
module counter_mod_cell
    import counter_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int MOD = 60
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  dir_e          up,
    input  logic          wrap_ok,
    input  logic          ld,
    input  logic [DW-1:0] ld_val,
    output logic [DW-1:0] q,
    output logic          at
);
    localparam logic [DW-1:0] MAXV = DW'(MOD - 1);

    assign at = (up == UP) ? (q == MAXV) : (q == '0);

    // NOTE: state registers use non-blocking assignments so every channel
    // samples the pre-edge values of its neighbours' terminal flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (ld) begin
            q <= DW'(clamp(32'(ld_val), 32'(MAXV)));
        end else if (en && !(at && !wrap_ok)) begin
            if (up == UP) q <= at ? '0   : q + 1'b1;
            else          q <= at ? MAXV : q - 1'b1;
        end
    end

endmodule

// File: rtl/counter_mod_chain.sv
// Cascade of NCH modulo counters (channel 0 least significant); each channel
// steps when every lower channel is at its terminal value and the chain is enabled.
module counter_mod_chain
    import counter_pkg::*;
#(
    parameter int                DW   = DW_DEF,
    parameter int                NCH  = 3,
    parameter logic [NCH*DW-1:0] MODS = 24'h183C3C
) (
    input  logic                clk,
    input  logic                reset,
    counter_mod_chain_if.slave  bus
);
    localparam logic [MODS_MAXW-1:0] MODS_X = MODS_MAXW'(MODS);
    localparam int LCW = (NCH > 1) ? $clog2(NCH) : 1;

    if (NCH < 1) begin : g_bad_nch
        $error("counter_mod_chain: NCH must be >= 1");
    end

    logic [NCH-1:0] en;
    logic [NCH-1:0] at;
    logic [NCH-1:0] ld;
    logic [NCH-1:0] tc;
    logic [DW-1:0]  q [NCH];
    logic           ld_ok;
    logic           wrap_ok;

    // Out-of-range channel selects drop the load; the chain still holds that cycle.
    assign ld_ok = (int'(bus.load_ch) < NCH);

    always_comb begin
        en    = '0;
        ld    = '0;
        en[0] = bus.ena & ~bus.load & ~reset;
        for (int i = 1; i < NCH; i++) en[i] = en[i-1] & at[i-1];
        for (int i = 0; i < NCH; i++) ld[i] = bus.load & ld_ok & (bus.load_ch == LCW'(i));
    end

    assign tc         = en & at;
    assign bus.tc     = tc;
    assign bus.tc_all = tc[NCH-1];
    // Saturation only pins the chain when the whole chain is at terminal.
    assign wrap_ok    = ~(bus.sat & tc[NCH-1]);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam int MOD_I = mod_at(MODS_X, i, DW);

        if (MOD_I < 2 || MOD_I > (2 ** DW) - 1) begin : g_bad_mod
            $error("counter_mod_chain: channel %0d modulus %0d out of range", i, MOD_I);
        end

        counter_mod_cell #(
            .DW  (DW),
            .MOD (MOD_I)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .en      (en[i]),
            .up      (dir_e'(bus.up)),
            .wrap_ok (wrap_ok),
            .ld      (ld[i]),
            .ld_val  (bus.load_val),
            .q       (q[i]),
            .at      (at[i])
        );
    end

    always_comb begin
        bus.count = '0;
        for (int i = 0; i < NCH; i++) bus.count[i*DW +: DW] = q[i];
    end

endmodule

// File: tb/tb_counter_mod_chain.sv
// Self-checking bench for the default 24h/60m/60s chain: directed time-of-day
// scenarios plus randomized traffic against a seconds-of-day reference model.
module tb_counter_mod_chain;
    localparam int DW  = 8;
    localparam int NCH = 3;
    localparam logic [23:0] MODS = 24'h183C3C;
    localparam int SPAN = 86400;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    counter_mod_chain_if #(.DW(DW), .NCH(NCH)) bus ();

    counter_mod_chain #(.DW(DW), .NCH(NCH), .MODS(MODS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int m_cnt [3];
    int mods  [3] = '{60, 60, 24};
    logic [2:0]  obs_tc;
    logic        obs_tc_all;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int total();
        return m_cnt[0] + 60 * m_cnt[1] + 3600 * m_cnt[2];
    endfunction

    function automatic void set_total(input int t);
        m_cnt[0] = t % 60;
        m_cnt[1] = (t / 60) % 60;
        m_cnt[2] = t / 3600;
    endfunction

    function automatic logic [23:0] pack(input int h, input int m, input int s);
        return {8'(h), 8'(m), 8'(s)};
    endfunction

    // Channel i carries when the low-order part of the time (mod product of
    // moduli 0..i) sits at its extreme for the current direction.
    function automatic logic [2:0] exp_tc(input logic r, input logic e, input logic u, input logic l);
        logic [2:0] t;
        int p;
        int tot;
        t = '0;
        p = 1;
        tot = total();
        for (int i = 0; i < 3; i++) begin
            p = p * mods[i];
            t[i] = e && !l && !r && ((tot % p) == (u ? p - 1 : 0));
        end
        return t;
    endfunction

    task automatic cycle(input logic r, input logic e, input logic u, input logic s,
                         input logic l, input logic [1:0] ch, input logic [7:0] v);
        logic [2:0] et;
        int t;
        @(negedge clk);
        reset        = r;
        bus.ena      = e;
        bus.up       = u;
        bus.sat      = s;
        bus.load     = l;
        bus.load_ch  = ch;
        bus.load_val = v;
        #1;
        et = exp_tc(r, e, u, l);
        obs_tc     = bus.tc;
        obs_tc_all = bus.tc_all;
        check("tc", 32'(bus.tc), 32'(et));
        check("tc_all", 32'(bus.tc_all), 32'(et[2]));
        @(posedge clk);
        if (r) begin
            set_total(0);
        end else if (l) begin
            if (ch < 3) m_cnt[ch] = (int'(v) > mods[ch] - 1) ? mods[ch] - 1 : int'(v);
        end else if (e) begin
            t = total();
            if (u) t = (t == SPAN - 1) ? (s ? t : 0) : t + 1;
            else   t = (t == 0) ? (s ? 0 : SPAN - 1) : t - 1;
            set_total(t);
        end
        #1;
        check("count", 32'(bus.count), 32'(pack(m_cnt[2], m_cnt[1], m_cnt[0])));
    endtask

    task automatic load_time(input int h, input int m, input int s);
        cycle(0, 0, 1, 0, 1, 2'd0, 8'(s));
        cycle(0, 0, 1, 0, 1, 2'd1, 8'(m));
        cycle(0, 0, 1, 0, 1, 2'd2, 8'(h));
    endtask

    initial begin
        reset = 1'b1;
        bus.ena = 0; bus.up = 1; bus.sat = 0; bus.load = 0;
        bus.load_ch = '0; bus.load_val = '0;
        set_total(0);

        // Reset wins over load and ena; no carry reported while in reset.
        cycle(1, 1, 1, 0, 1, 2'd0, 8'd5);
        cycle(1, 1, 0, 0, 0, 2'd0, 8'd0);
        check("t1_tc", 32'(obs_tc), 32'd0);
        check("t1_count", 32'(bus.count), 32'd0);

        // Seconds rollover carries into minutes.
        load_time(0, 0, 59);
        cycle(0, 1, 1, 0, 0, 2'd0, 8'd0);
        check("t2_tc", 32'(obs_tc), 32'b001);
        check("t2_count", 32'(bus.count), 32'(pack(0, 1, 0)));

        // Full-day wrap.
        load_time(23, 59, 59);
        cycle(0, 1, 1, 0, 0, 2'd0, 8'd0);
        check("t3_tc", 32'(obs_tc), 32'b111);
        check("t3_tc_all", 32'(obs_tc_all), 32'd1);
        check("t3_count", 32'(bus.count), 32'd0);

        // Saturation pins the chain at all-max.
        load_time(23, 59, 59);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, 1, 0, 2'd0, 8'd0);
            check("t4_tc_all", 32'(obs_tc_all), 32'd1);
        end
        check("t4_count", 32'(bus.count), 32'(pack(23, 59, 59)));

        // Downward borrow through the whole chain, then plain decrements.
        cycle(1, 0, 0, 0, 0, 2'd0, 8'd0);
        cycle(0, 1, 0, 0, 0, 2'd0, 8'd0);
        check("t5_tc", 32'(obs_tc), 32'b111);
        check("t5_wrap", 32'(bus.count), 32'(pack(23, 59, 59)));
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 2'd0, 8'd0);
        check("t5_count", 32'(bus.count), 32'(pack(23, 59, 56)));

        // Clamped load and out-of-range channel select.
        cycle(0, 1, 1, 0, 1, 2'd1, 8'd75);
        check("t6_clamp", 32'(bus.count), 32'(pack(23, 59, 56)));
        load_time(5, 10, 20);
        cycle(0, 1, 1, 0, 1, 2'd1, 8'd75);
        check("t6_clamp2", 32'(bus.count), 32'(pack(5, 59, 20)));
        cycle(0, 1, 1, 0, 1, 2'd3, 8'd7);
        check("t6_badch", 32'(bus.count), 32'(pack(5, 59, 20)));

        // Randomized traffic; occasional loads near the edges of each channel.
        for (int n = 0; n < 3000; n++) begin
            int k;
            logic [7:0] v;
            k = $urandom_range(0, 99);
            v = (k % 3 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(55, 60));
            if (k < 2)
                cycle(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), v);
            else if (k < 14)
                cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 2'($urandom), v);
            else
                cycle(0, (k % 5) != 0, (n / 400) % 2 == 0 ? (k % 7 != 0) : (k % 7 == 0),
                      (k % 4 == 0), 1'b0, 2'd0, 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
